// File: rtl/usb_speed_sequencer_if.sv
// Bus bundle between the USB speed sequencer and its controller.
// Latency: none, pure wiring; all timing lives in usb_speed_sequencer.
// Backpressure: none; I_start/I_abort are single-cycle pulses, status is level.
//
// Ports carried:
//   control in : I_start, I_abort, I_mode[1:0], I_timeout[pCOUNTER_WIDTH-1:0], I_max_retries[3:0]
//   detector   : detect_speed_i[1:0] (in), detect_restart_o (out)
//   status out : O_speed[1:0], O_busy, O_done, O_fail, O_retries[3:0], O_state[2:0]
// master = controller / testbench side, slave = sequencer side.

`ifndef USB_SPEED_AUTO
`define USB_SPEED_AUTO 2'b00
`endif
`ifndef USB_SPEED_LS
`define USB_SPEED_LS 2'b01
`endif
`ifndef USB_SPEED_FS
`define USB_SPEED_FS 2'b10
`endif
`ifndef USB_SPEED_HS
`define USB_SPEED_HS 2'b11
`endif

interface usb_speed_sequencer_if #(
    parameter int pCOUNTER_WIDTH = 24
);
    logic                      I_start;
    logic                      I_abort;
    logic [1:0]                I_mode;
    logic [pCOUNTER_WIDTH-1:0] I_timeout;
    logic [3:0]                I_max_retries;
    logic [1:0]                detect_speed_i;
    logic                      detect_restart_o;
    logic [1:0]                O_speed;
    logic                      O_busy;
    logic                      O_done;
    logic                      O_fail;
    logic [3:0]                O_retries;
    logic [2:0]                O_state;

    modport master (
        output I_start, I_abort, I_mode, I_timeout, I_max_retries, detect_speed_i,
        input  detect_restart_o, O_speed, O_busy, O_done, O_fail, O_retries, O_state
    );

    modport slave (
        input  I_start, I_abort, I_mode, I_timeout, I_max_retries, detect_speed_i,
        output detect_restart_o, O_speed, O_busy, O_done, O_fail, O_retries, O_state
    );
endinterface

// File: rtl/usb_speed_sequencer.sv
// USB link speed sequencer: restarts the autodetector, waits for a result with timeout/retry, or forces a fixed speed.
// Latency: fixed speed -> DONE one cycle after I_start; autodetect -> RESTART(1) + SETTLE(pSETTLE) + WAIT(<= I_timeout+1) per attempt.
// Backpressure: none; inputs are sampled every cycle, I_abort beats I_start, status outputs are registered levels.
//
// Ports: cwusb_clk (rising edge), reset_i (synchronous, active-high), bus (usb_speed_sequencer_if.slave).
// Optional feature macro: USB_SPEED_SEQ_RETRY_EN -- when undefined, I_max_retries is ignored (treated as 0),
// the first timeout goes straight to FAIL, O_retries stays 0 and BACKOFF is never entered.

`ifndef USB_SPEED_AUTO
`define USB_SPEED_AUTO 2'b00
`endif

module usb_speed_sequencer #(
    parameter int pCOUNTER_WIDTH = 24,
    parameter int pSETTLE        = 8
) (
    input  logic                 cwusb_clk,
    input  logic                 reset_i,
    usb_speed_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESTART = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_WAIT    = 3'd3,
        ST_BACKOFF = 3'd4,
        ST_DONE    = 3'd5,
        ST_FAIL    = 3'd6
    } state_t;

    localparam int              pSW          = (pSETTLE > 1) ? $clog2(pSETTLE) : 1;
    localparam logic [pSW-1:0]  pSETTLE_LAST = pSW'(pSETTLE - 1);

    state_t                    r_state;
    logic [pCOUNTER_WIDTH-1:0] r_timer;
    logic [pSW-1:0]            r_settle;
    logic [3:0]                r_retries;
    logic [1:0]                r_speed;
    logic                      r_restart;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_fail;

    logic [3:0]                w_max_retries;
    logic                      w_result;

`ifdef USB_SPEED_SEQ_RETRY_EN
    assign w_max_retries = bus.I_max_retries;
`else
    // Retries disabled: compare against zero so every timeout is final.
    logic w_unused_max_retries;
    assign w_max_retries        = 4'd0;
    assign w_unused_max_retries = ^bus.I_max_retries;
`endif

    assign w_result = (bus.detect_speed_i != `USB_SPEED_AUTO);

    // Status flags {busy, done, fail} for the state being entered, so they
    // change on the same edge as O_state.
    function automatic logic [2:0] f_flags(input state_t s);
        case (s)
            ST_RESTART, ST_SETTLE, ST_WAIT, ST_BACKOFF: f_flags = 3'b100;
            ST_DONE:                                     f_flags = 3'b010;
            ST_FAIL:                                     f_flags = 3'b001;
            default:                                     f_flags = 3'b000;
        endcase
    endfunction

    always_ff @(posedge cwusb_clk) begin
        if (reset_i) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_settle  <= '0;
            r_retries <= 4'd0;
            r_speed   <= `USB_SPEED_AUTO;
            r_restart <= 1'b0;
            {r_busy, r_done, r_fail} <= 3'b000;
        end else begin
            // Restart is a strobe: only the transitions into RESTART raise it.
            r_restart <= 1'b0;

            if (bus.I_abort) begin
                // Speed and retry count are left as-is for post-mortem reads.
                r_state <= ST_IDLE;
                {r_busy, r_done, r_fail} <= f_flags(ST_IDLE);
            end else if (bus.I_start) begin
                r_retries <= 4'd0;
                if (bus.I_mode == `USB_SPEED_AUTO) begin
                    r_state   <= ST_RESTART;
                    r_restart <= 1'b1;
                    r_speed   <= `USB_SPEED_AUTO;
                    {r_busy, r_done, r_fail} <= f_flags(ST_RESTART);
                end else begin
                    // Forced speed: no detector involvement at all.
                    r_state <= ST_DONE;
                    r_speed <= bus.I_mode;
                    {r_busy, r_done, r_fail} <= f_flags(ST_DONE);
                end
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE, ST_FAIL: begin
                        // Hold until the next start/abort.
                    end

                    ST_RESTART: begin
                        r_state  <= ST_SETTLE;
                        r_settle <= '0;
                        {r_busy, r_done, r_fail} <= f_flags(ST_SETTLE);
                    end

                    // Detector output is untrustworthy right after a restart.
                    ST_SETTLE: begin
                        if (r_settle == pSETTLE_LAST) begin
                            r_state <= ST_WAIT;
                            r_timer <= '0;
                            {r_busy, r_done, r_fail} <= f_flags(ST_WAIT);
                        end else begin
                            r_settle <= r_settle + 1'b1;
                        end
                    end

                    // A result seen on the timeout cycle still wins.
                    ST_WAIT: begin
                        if (w_result) begin
                            r_state <= ST_DONE;
                            r_speed <= bus.detect_speed_i;
                            {r_busy, r_done, r_fail} <= f_flags(ST_DONE);
                        end else if (r_timer == bus.I_timeout) begin
                            if (r_retries < w_max_retries) begin
                                r_state   <= ST_BACKOFF;
                                r_retries <= r_retries + 4'd1;
                                {r_busy, r_done, r_fail} <= f_flags(ST_BACKOFF);
                            end else begin
                                r_state <= ST_FAIL;
                                r_speed <= `USB_SPEED_AUTO;
                                {r_busy, r_done, r_fail} <= f_flags(ST_FAIL);
                            end
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end

                    ST_BACKOFF: begin
                        r_state   <= ST_RESTART;
                        r_restart <= 1'b1;
                        {r_busy, r_done, r_fail} <= f_flags(ST_RESTART);
                    end

                    // Unused encoding 7 recovers to IDLE.
                    default: begin
                        r_state <= ST_IDLE;
                        {r_busy, r_done, r_fail} <= f_flags(ST_IDLE);
                    end
                endcase
            end
        end
    end

    assign bus.detect_restart_o = r_restart;
    assign bus.O_speed          = r_speed;
    assign bus.O_busy           = r_busy;
    assign bus.O_done           = r_done;
    assign bus.O_fail           = r_fail;
    assign bus.O_retries        = r_retries;
    assign bus.O_state          = r_state;

endmodule

// File: tb/tb_usb_speed_sequencer.sv
// Testbench for usb_speed_sequencer: directed sequences, expected terminal events queued by stimulus.
// A monitor pops one expectation whenever O_state enters IDLE, DONE or FAIL and checks it.
// Restart pulses and busy/done/fail consistency are accumulated between events.

`ifndef USB_SPEED_AUTO
`define USB_SPEED_AUTO 2'b00
`endif
`ifndef USB_SPEED_LS
`define USB_SPEED_LS 2'b01
`endif
`ifndef USB_SPEED_FS
`define USB_SPEED_FS 2'b10
`endif
`ifndef USB_SPEED_HS
`define USB_SPEED_HS 2'b11
`endif

module tb_usb_speed_sequencer;
    localparam int CW     = 24;
    localparam int SETTLE = 8;
`ifdef USB_SPEED_SEQ_RETRY_EN
    localparam int RETRY_EN = 1;
`else
    localparam int RETRY_EN = 0;
`endif

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_FAIL = 3'd6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    usb_speed_sequencer_if #(.pCOUNTER_WIDTH(CW)) bus ();

    usb_speed_sequencer #(
        .pCOUNTER_WIDTH(CW),
        .pSETTLE       (SETTLE)
    ) dut (
        .cwusb_clk(clk),
        .reset_i  (rst),
        .bus      (bus)
    );

    typedef struct {
        int         id;
        logic [2:0] state;
        logic [1:0] speed;
        logic [3:0] retries;
        int         pulses;
        int         cyc;     // -1: arrival cycle not checked
    } exp_t;

    exp_t       q[$];
    int         cyc       = 0;
    int         n_checks  = 0;
    int         n_pass    = 0;
    int         pulse_cnt = 0;
    int         inv_err   = 0;
    int         next_id   = 0;
    logic [2:0] mon_prev  = 3'd7;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int id, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s (event %0d): got %0d, expected %0d", nm, id, act, exp);
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.detect_restart_o) pulse_cnt++;
            if ((bus.O_busy !== (bus.O_state inside {[3'd1:3'd4]})) ||
                (bus.O_done !== (bus.O_state == S_DONE)) ||
                (bus.O_fail !== (bus.O_state == S_FAIL)))
                inv_err++;
            if (bus.O_state != mon_prev && (bus.O_state == S_IDLE || bus.O_state == S_DONE || bus.O_state == S_FAIL)) begin
                if (q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_event: state %0d at cycle %0d, expected no event", bus.O_state, cyc);
                end else begin
                    e = q.pop_front();
                    check("state",   e.id, int'(bus.O_state),   int'(e.state));
                    check("speed",   e.id, int'(bus.O_speed),   int'(e.speed));
                    check("retries", e.id, int'(bus.O_retries), int'(e.retries));
                    check("restart_pulses", e.id, pulse_cnt, e.pulses);
                    check("flag_consistency_errors", e.id, inv_err, 0);
                    if (e.cyc >= 0) check("arrival_cycle", e.id, cyc, e.cyc);
                end
                pulse_cnt = 0;
                inv_err   = 0;
            end
            mon_prev = bus.O_state;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic [2:0] st, input logic [1:0] sp, input int rt, input int pl, input int c);
        exp_t e;
        e.id = next_id; e.state = st; e.speed = sp; e.retries = 4'(rt); e.pulses = pl; e.cyc = c;
        next_id++;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL drain (event %0d): %0d events still pending after %0d cycles, expected 0", q[0].id, q.size(), budget);
            q.delete();
        end
    endtask

    task automatic start(input logic [1:0] mode);
        bus.I_mode  = mode;
        bus.I_start = 1'b1;
        tick();
        bus.I_start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int k;
        int n;
        bus.I_start        = 1'b0;
        bus.I_abort        = 1'b0;
        bus.I_mode         = `USB_SPEED_AUTO;
        bus.I_timeout      = 24'd1000;
        bus.I_max_retries  = 4'd0;
        bus.detect_speed_i = `USB_SPEED_AUTO;

        // Reset state
        push(S_IDLE, `USB_SPEED_AUTO, 0, 0, -1);
        repeat (3) tick();
        rst = 1'b0;
        drain(5);

        // Autodetect, HS reported at WAIT timer 20
        k = cyc;
        push(S_DONE, `USB_SPEED_HS, 0, 1, k + 31);
        start(`USB_SPEED_AUTO);
        wait_until(k + 30);
        bus.detect_speed_i = `USB_SPEED_HS;
        tick();
        bus.detect_speed_i = `USB_SPEED_AUTO;
        drain(50);

        // Abort from DONE keeps speed
        k = cyc;
        push(S_IDLE, `USB_SPEED_HS, 0, 0, k + 1);
        bus.I_abort = 1'b1;
        tick();
        bus.I_abort = 1'b0;
        drain(5);

        // Forced FS
        k = cyc;
        push(S_DONE, `USB_SPEED_FS, 0, 0, k + 1);
        start(`USB_SPEED_FS);
        drain(5);

        // Reset while DONE clears speed
        k = cyc;
        push(S_IDLE, `USB_SPEED_AUTO, 0, 0, k + 1);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        drain(5);

        // Timeout 100, max retries 2, no result
        bus.I_timeout     = 24'd100;
        bus.I_max_retries = 4'd2;
        n = (RETRY_EN != 0) ? 3 : 1;
        k = cyc;
        push(S_FAIL, `USB_SPEED_AUTO, n - 1, n, k + n * 111);
        start(`USB_SPEED_AUTO);
        drain(400);

        // Timeout 20, max retries 5
        bus.I_timeout     = 24'd20;
        bus.I_max_retries = 4'd5;
        n = (RETRY_EN != 0) ? 6 : 1;
        k = cyc;
        push(S_FAIL, `USB_SPEED_AUTO, n - 1, n, k + n * 31);
        start(`USB_SPEED_AUTO);
        drain(250);

        // LS during SETTLE ignored; LS on the timeout cycle wins
        bus.I_timeout     = 24'd30;
        bus.I_max_retries = 4'd0;
        k = cyc;
        push(S_DONE, `USB_SPEED_LS, 0, 1, k + 41);
        start(`USB_SPEED_AUTO);
        wait_until(k + 2);
        bus.detect_speed_i = `USB_SPEED_LS;
        wait_until(k + 10);
        bus.detect_speed_i = `USB_SPEED_AUTO;
        wait_until(k + 40);
        bus.detect_speed_i = `USB_SPEED_LS;
        tick();
        bus.detect_speed_i = `USB_SPEED_AUTO;
        drain(20);

        // Abort + start together during WAIT
        bus.I_timeout = 24'd1000;
        k = cyc;
        push(S_IDLE, `USB_SPEED_AUTO, 0, 1, k + 16);
        start(`USB_SPEED_AUTO);
        wait_until(k + 15);
        bus.I_start = 1'b1;
        bus.I_abort = 1'b1;
        tick();
        bus.I_start = 1'b0;
        bus.I_abort = 1'b0;
        drain(30);

        // Reset during SETTLE, then no further restart pulse
        k = cyc;
        push(S_IDLE, `USB_SPEED_AUTO, 0, 1, k + 5);
        start(`USB_SPEED_AUTO);
        wait_until(k + 4);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        drain(10);
        repeat (20) tick();
        check("stray_restart_after_reset", -1, pulse_cnt, 0);
        check("idle_state_after_reset", -1, int'(bus.O_state), int'(S_IDLE));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        n_checks++;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
